fetch_control: RTL and testbench
================================

FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: PC value requested on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: fetch-wait limit, used only when FETCH_TIMEOUT_EN is defined.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset; one clock, reset is synchronous and active-high (nRST=1 resets on the CLK edge).
REQ-005 SHALL have port pc_cur  input  32  current PC register value.
REQ-006 SHALL have port ihit  input  1  instruction memory returns data this cycle.
REQ-007 SHALL have port stall  input  1  downstream cannot accept an instruction.
REQ-008 SHALL have ports br_taken/jmp/jr  input  1 each, with br_tgt/jmp_tgt/jr_tgt  input  32 each: redirect pulses and targets.
REQ-009 SHALL have port halt  input  1  halt instruction decoded.
REQ-010 SHALL have ports iREN  output  1 and imemaddr  output  32: instruction read request and address.
REQ-011 SHALL have ports pc_wen  output  1 and pc_next  output  32: PC register write enable and value.
REQ-012 SHALL have ports instr_valid  output  1, halted  output  1 and fetch_err  output  1.

Function
REQ-013 SHALL implement FSM states FETCH, HOLD and HALT.
REQ-014 In FETCH: iREN=1 and imemaddr=pc_cur.
REQ-015 In FETCH, ihit=1 and stall=0: pc_wen=1 and instr_valid=1 that same cycle; state stays FETCH.
REQ-016 In FETCH, ihit=1 and stall=1: pc_wen=0; next state HOLD.
REQ-017 In HOLD: iREN=0, instr_valid=1, pc_wen=0; when stall=0, pc_wen=1 that cycle and next state FETCH.
REQ-018 pc_next priority: pending/current jr > jmp > br_taken > pc_cur+4.
REQ-019 pc_cur+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-020 Targets SHALL have bits [1:0] forced to 00.
REQ-021 A redirect pulse in a cycle without pc_wen SHALL be held in a pending register, highest priority winning, and applied at the next pc_wen.
REQ-022 When a pending redirect is applied, instr_valid SHALL be 0 (fetched word squashed).
REQ-023 The pending register SHALL clear on the pc_wen that consumes it.
REQ-024 A new redirect coinciding with pc_wen SHALL be used directly and SHALL NOT be stored.
REQ-025 halt=1 in any state SHALL move to HALT next cycle; the halting cycle's pc_wen is suppressed.
REQ-026 HALT SHALL be terminal until reset: iREN=0, pc_wen=0, instr_valid=0, halted=1.
REQ-027 Redirect and halt in the same cycle: halt wins.

Reset
REQ-028 While nRST=1: state=FETCH, pending cleared, halted=0, fetch_err=0, wait counter=0.
REQ-029 While nRST=1: pc_wen=1 and pc_next=RESET_PC, so the PC register loads RESET_PC.
REQ-030 Reset asserted mid-HOLD or mid-wait SHALL abandon the instruction without asserting instr_valid.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined: an 8+ bit counter SHALL count consecutive FETCH cycles with ihit=0 and clear on ihit.
REQ-032 With FETCH_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES, fetch_err=1 (sticky) and next state HALT.
REQ-033 Without FETCH_TIMEOUT_EN: no counter; fetch_err tied 0; FETCH waits indefinitely.

Structure
REQ-034 cpu_types_pkg SHALL hold word_t, fetch_state_t (FETCH/HOLD/HALT) and npc_sel_t (SEQ/BR/JMP/JR).
REQ-035 Sub-module npc_select SHALL implement the combinational priority mux, alignment and +4 logic.

Verification
REQ-036 Reset with RESET_PC=32'h100 -> pc_wen=1, pc_next=32'h100; after release: iREN=1, imemaddr=pc_cur.
REQ-037 pc_cur=32'h10, ihit=1, stall=0 -> pc_next=32'h14, instr_valid=1; pc_cur=32'hFFFFFFFC -> pc_next=0.
REQ-038 ihit with stall for 3 cycles -> HOLD with instr_valid=1 and pc_wen=0 for 3 cycles, then pc_wen=1.
REQ-039 jmp=1, jmp_tgt=32'h203 while waiting for ihit -> on ihit: pc_next=32'h200, instr_valid=0.
REQ-040 jr and br_taken together, jr_tgt=32'h40 -> pc_next=32'h40; halt in the same cycle -> HALT with halted=1.
REQ-041 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, ihit held 0 -> fetch_err=1 and halted=1 after 4 wait cycles.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: machine word, fetch FSM states and next-PC source select.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Encoding order doubles as redirect priority: JR > JMP > BR > SEQ.
    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        JMP = 2'd2,
        JR  = 2'd3
    } npc_sel_t;

    localparam word_t ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/npc_select.sv
// Next-PC mux: merges the live redirect with any pending one, aligns targets, else pc_cur+4.
// Purely combinational; no backpressure.
module npc_select
    import cpu_types_pkg::*;
(
    input  word_t    pc_cur,
    input  logic     br_taken,
    input  logic     jmp,
    input  logic     jr,
    input  word_t    br_tgt,
    input  word_t    jmp_tgt,
    input  word_t    jr_tgt,
    input  npc_sel_t pend_sel,
    input  word_t    pend_tgt,
    output npc_sel_t sel,
    output word_t    npc
);

    npc_sel_t cur_sel;
    word_t    cur_tgt;
    word_t    tgt;

    always_comb begin
        cur_sel = SEQ;
        cur_tgt = br_tgt;
        if (jr) begin
            cur_sel = JR;
            cur_tgt = jr_tgt;
        end else if (jmp) begin
            cur_sel = JMP;
            cur_tgt = jmp_tgt;
        end else if (br_taken) begin
            cur_sel = BR;
        end
    end

    // On equal priority the live redirect is the newer one and wins.
    always_comb begin
        if (cur_sel != SEQ && cur_sel >= pend_sel) begin
            sel = cur_sel;
            tgt = cur_tgt;
        end else begin
            sel = pend_sel;
            tgt = pend_tgt;
        end
    end

    assign npc = (sel == SEQ) ? (pc_cur + 32'd4) : (tgt & ALIGN_MASK);

endmodule

// File: rtl/fetch_control.sv
// Fetch FSM (FETCH/HOLD/HALT) driving I-mem requests and PC writes; holds redirects until next PC write.
// Optional fetch-wait watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_control
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC       = 32'h0000_0000,
    parameter int    TIMEOUT_CYCLES = 255
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t pc_cur,
    input  logic  ihit,
    input  logic  stall,
    input  logic  br_taken,
    input  logic  jmp,
    input  logic  jr,
    input  word_t br_tgt,
    input  word_t jmp_tgt,
    input  word_t jr_tgt,
    input  logic  halt,
    output logic  iREN,
    output word_t imemaddr,
    output logic  pc_wen,
    output word_t pc_next,
    output logic  instr_valid,
    output logic  halted,
    output logic  fetch_err
);

    fetch_state_t state, state_nxt;
    npc_sel_t     pend_sel, eff_sel;
    word_t        pend_tgt, npc;
    logic         iren_c, wen_c, iv_raw, timeout, err_q;

    npc_select u_npc (
        .pc_cur   (pc_cur),
        .br_taken (br_taken),
        .jmp      (jmp),
        .jr       (jr),
        .br_tgt   (br_tgt),
        .jmp_tgt  (jmp_tgt),
        .jr_tgt   (jr_tgt),
        .pend_sel (pend_sel),
        .pend_tgt (pend_tgt),
        .sel      (eff_sel),
        .npc      (npc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] wait_cnt;

    assign timeout = (state == FETCH) && !ihit && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (nRST) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != FETCH || ihit)
                wait_cnt <= '0;
            else if (!timeout)
                wait_cnt <= wait_cnt + CW'(1);
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_q   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state    <= FETCH;
            pend_sel <= SEQ;
            pend_tgt <= '0;
        end else begin
            state <= state_nxt;
            if (state != HALT) begin
                if (wen_c) begin
                    pend_sel <= SEQ;
                end else if (eff_sel != SEQ) begin
                    pend_sel <= eff_sel;
                    pend_tgt <= npc;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        iren_c    = 1'b0;
        wen_c     = 1'b0;
        iv_raw    = 1'b0;
        case (state)
            FETCH: begin
                iren_c = 1'b1;
                if (ihit && !stall) begin
                    wen_c  = 1'b1;
                    iv_raw = 1'b1;
                end else if (ihit) begin
                    state_nxt = HOLD;
                end else if (timeout) begin
                    state_nxt = HALT;
                end
            end
            HOLD: begin
                iv_raw = 1'b1;
                if (!stall) begin
                    wen_c     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
        if (halt) begin
            state_nxt = HALT;
            wen_c     = 1'b0;
        end
    end

    // Reset overrides everything so the PC register loads RESET_PC and nothing is issued.
    assign iREN        = iren_c & ~nRST;
    assign imemaddr    = pc_cur;
    assign pc_wen      = nRST | wen_c;
    assign pc_next     = nRST ? RESET_PC : npc;
    assign instr_valid = ~nRST & iv_raw & ~(wen_c & (pend_sel != SEQ));
    assign halted      = ~nRST & (state == HALT);
    assign fetch_err   = ~nRST & err_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control: expected outputs queued per step, popped and checked mid-cycle.
module tb_fetch_control;
    import cpu_types_pkg::*;

    logic  CLK, nRST, ihit, stall, br_taken, jmp, jr, halt;
    word_t pc_cur, br_tgt, jmp_tgt, jr_tgt;
    logic  iREN, pc_wen, instr_valid, halted, fetch_err;
    word_t imemaddr, pc_next;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        iren;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] npc;
        logic        npc_chk;
        logic        iv;
        logic        hlt;
        logic        ferr;
    } exp_t;

    exp_t sb[$];

    fetch_control #(.RESET_PC(32'h100), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .nRST(nRST), .pc_cur(pc_cur), .ihit(ihit), .stall(stall),
        .br_taken(br_taken), .jmp(jmp), .jr(jr),
        .br_tgt(br_tgt), .jmp_tgt(jmp_tgt), .jr_tgt(jr_tgt), .halt(halt),
        .iREN(iREN), .imemaddr(imemaddr), .pc_wen(pc_wen), .pc_next(pc_next),
        .instr_valid(instr_valid), .halted(halted), .fetch_err(fetch_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue this cycle's expectation, compare at the falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic e_iren, input word_t e_addr,
                        input logic e_wen, input word_t e_npc, input logic e_npc_chk,
                        input logic e_iv, input logic e_hlt, input logic e_ferr);
        exp_t e;
        sb.push_back({e_iren, e_addr, e_wen, e_npc, e_npc_chk, e_iv, e_hlt, e_ferr});
        @(negedge CLK);
        e = sb.pop_front();
        chk({tag, ".iREN"}, {31'd0, iREN}, {31'd0, e.iren});
        if (e.iren) chk({tag, ".imemaddr"}, imemaddr, e.addr);
        chk({tag, ".pc_wen"}, {31'd0, pc_wen}, {31'd0, e.wen});
        if (e.npc_chk) chk({tag, ".pc_next"}, pc_next, e.npc);
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e.iv});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
        chk({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, e.ferr});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1; ihit = 1'b0; stall = 1'b0; halt = 1'b0;
        br_taken = 1'b0; jmp = 1'b0; jr = 1'b0;
        pc_cur = 32'h0; br_tgt = 32'h0; jmp_tgt = 32'h0; jr_tgt = 32'h0;

        //            tag         iren addr          wen npc           chk iv hlt err
        step("rst0",   0, 32'h0,         1, 32'h100,       1, 0, 0, 0);
        step("rst1",   0, 32'h0,         1, 32'h100,       1, 0, 0, 0);

        nRST = 1'b0; pc_cur = 32'h100;
        step("fetch0", 1, 32'h100,       0, 32'h104,       1, 0, 0, 0);

        pc_cur = 32'h10; ihit = 1'b1;
        step("seq",    1, 32'h10,        1, 32'h14,        1, 1, 0, 0);
        pc_cur = 32'hFFFF_FFFC;
        step("wrap",   1, 32'hFFFF_FFFC, 1, 32'h0,         1, 1, 0, 0);

        pc_cur = 32'h20; stall = 1'b1;
        step("stall",  1, 32'h20,        0, 32'h24,        1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("hold",   0, 32'h20,        0, 32'h24,        1, 1, 0, 0);
        stall = 1'b0;
        step("unhold", 0, 32'h20,        1, 32'h24,        1, 1, 0, 0);

        pc_cur = 32'h24; ihit = 1'b0; jmp = 1'b1; jmp_tgt = 32'h203;
        step("jmpw",   1, 32'h24,        0, 32'h200,       1, 0, 0, 0);
        jmp = 1'b0; jmp_tgt = 32'h0;
        step("pendw",  1, 32'h24,        0, 32'h200,       1, 0, 0, 0);
        ihit = 1'b1;
        step("squash", 1, 32'h24,        1, 32'h200,       1, 0, 0, 0);
        pc_cur = 32'h200;
        step("pclr",   1, 32'h200,       1, 32'h204,       1, 1, 0, 0);

        jr = 1'b1; br_taken = 1'b1; jr_tgt = 32'h40; br_tgt = 32'h80;
        step("jrbr",   1, 32'h200,       1, 32'h40,        1, 1, 0, 0);
        jr = 1'b0; br_taken = 1'b0; pc_cur = 32'h40;
        step("nostore",1, 32'h40,        1, 32'h44,        1, 1, 0, 0);

        ihit = 1'b0; br_taken = 1'b1; br_tgt = 32'h81;
        step("brpend", 1, 32'h40,        0, 32'h80,        1, 0, 0, 0);
        br_taken = 1'b1; jr = 1'b1; jr_tgt = 32'h43; halt = 1'b1;
        step("jrhalt", 1, 32'h40,        0, 32'h40,        1, 0, 0, 0);
        br_taken = 1'b0; jr = 1'b0; halt = 1'b0; ihit = 1'b1;
        step("halt0",  0, 32'h40,        0, 32'h0,         0, 0, 1, 0);
        step("halt1",  0, 32'h40,        0, 32'h0,         0, 0, 1, 0);

        nRST = 1'b1;
        step("rsthlt", 0, 32'h40,        1, 32'h100,       1, 0, 0, 0);
        nRST = 1'b0; pc_cur = 32'h300; stall = 1'b1;
        step("stall2", 1, 32'h300,       0, 32'h304,       1, 0, 0, 0);
        nRST = 1'b1;
        step("rsthold",0, 32'h300,       1, 32'h100,       1, 0, 0, 0);
        nRST = 1'b0; pc_cur = 32'h100; ihit = 1'b0; stall = 1'b0;
        step("abandon",1, 32'h100,       0, 32'h104,       1, 0, 0, 0);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 3; i++)
            step("wait",   1, 32'h100,       0, 32'h104,       1, 0, 0, 0);
        step("tmo",    0, 32'h100,       0, 32'h0,         0, 0, 1, 1);
        step("tmo2",   0, 32'h100,       0, 32'h0,         0, 0, 1, 1);
        nRST = 1'b1;
        step("rsterr", 0, 32'h100,       1, 32'h100,       1, 0, 0, 0);
`else
        for (int i = 0; i < 8; i++)
            step("wait",   1, 32'h100,       0, 32'h104,       1, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
